mor1kx_sync_fifo_sclk: RTL and testbench

//  Single-clock show-ahead FIFO: the producer/consumer control end wrapped around a
//  1-cycle-latency dual-port RAM (port A write, port B read) plus an output register.

---
 rtl/mor1kx_sync_fifo_sclk.sv | 103 ++++++++++
 tb/tb_mor1kx_sync_fifo_sclk.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_sync_fifo_sclk.sv
// Single-clock show-ahead FIFO: dual-port RAM plus an output register that always
// holds the head word, with write-into-empty bypass so there are no read bubbles.
module mor1kx_sync_fifo_sclk #(
   parameter int DEPTH_WIDTH = 4,
   parameter int DATA_WIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush_i,
   input  logic                   write_i,
   input  logic [DATA_WIDTH-1:0]  data_i,
   output logic                   full_o,
   input  logic                   read_i,
   output logic [DATA_WIDTH-1:0]  data_o,
   output logic                   empty_o,
   output logic [DEPTH_WIDTH:0]   count_o,
   output logic                   overflow_o,
   output logic                   underflow_o
);

   localparam int CW    = DEPTH_WIDTH + 1;
   localparam int DEPTH = 1 << DEPTH_WIDTH;

   typedef enum logic {EMPTY, HEAD} state_t;

   state_t                  state;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [DEPTH_WIDTH-1:0]  wr_ptr;
   logic [DEPTH_WIDTH-1:0]  rd_ptr;
   logic [DEPTH_WIDTH-1:0]  rd_ptr_inc;
   logic                    wr_acc;
   logic                    rd_acc;
   logic                    bypass;
   logic [CW-1:0]           count_nxt;

   assign empty_o    = (state == EMPTY);
   assign wr_acc     = write_i & ~full_o;
   assign rd_acc     = read_i & ~empty_o;
   assign rd_ptr_inc = rd_ptr + DEPTH_WIDTH'(1);

   // The incoming word becomes the head directly when nothing older remains to show.
   assign bypass = wr_acc & ((count_o == '0) | ((count_o == CW'(1)) & rd_acc));

   // NOTE: combinational blocks use blocking '=' and assign a default first so no latch is inferred.
   always_comb begin
      count_nxt = count_o;
      if (wr_acc && !rd_acc)
         count_nxt = count_o + CW'(1);
      else if (rd_acc && !wr_acc)
         count_nxt = count_o - CW'(1);
   end

   // NOTE: storage array carries no reset so it maps onto plain RAM; valid words are tracked by the pointers.
   always_ff @(posedge clk) begin
      if (!rst && !flush_i && wr_acc)
         mem[wr_ptr] <= data_i;
   end

   // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= EMPTY;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_o     <= '0;
         full_o      <= 1'b0;
         overflow_o  <= 1'b0;
         underflow_o <= 1'b0;
         data_o      <= '0;
      end else if (flush_i) begin
         state       <= EMPTY;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_o     <= '0;
         full_o      <= 1'b0;
         overflow_o  <= 1'b0;
         underflow_o <= 1'b0;
      end else begin
         overflow_o  <= write_i & full_o;
         underflow_o <= read_i & empty_o;
         count_o     <= count_nxt;
         full_o      <= (count_nxt == CW'(DEPTH));
         if (wr_acc)
            wr_ptr <= wr_ptr + DEPTH_WIDTH'(1);
         if (rd_acc)
            rd_ptr <= rd_ptr_inc;

         // Output register doubles as the RAM read-port register; bypass forwards
         // the write when the read address would coincide with the write address.
         if (bypass)
            data_o <= data_i;
         else if (rd_acc && (count_o > CW'(1)))
            data_o <= mem[rd_ptr_inc];

         case (state)
            EMPTY: if (wr_acc) state <= HEAD;
            HEAD:  if (count_nxt == '0) state <= EMPTY;
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_mor1kx_sync_fifo_sclk.sv
// Self-checking bench: queue-based FIFO model compared every cycle, plus directed scenarios.
module tb_mor1kx_sync_fifo_sclk;

   localparam int DW    = 4;
   localparam int WW    = 32;
   localparam int DEPTH = 1 << DW;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           flush_i = 1'b0;
   logic           write_i = 1'b0;
   logic [WW-1:0]  data_i = '0;
   logic           read_i = 1'b0;
   logic           full_o;
   logic [WW-1:0]  data_o;
   logic           empty_o;
   logic [DW:0]    count_o;
   logic           overflow_o;
   logic           underflow_o;

   int n_checks = 0;
   int n_fails  = 0;

   mor1kx_sync_fifo_sclk #(.DEPTH_WIDTH(DW), .DATA_WIDTH(WW)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .write_i(write_i), .data_i(data_i), .full_o(full_o),
      .read_i(read_i), .data_o(data_o), .empty_o(empty_o),
      .count_o(count_o), .overflow_o(overflow_o), .underflow_o(underflow_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: the FIFO is just a queue; flags and pulses follow from its size.
   logic [WW-1:0] q[$];
   logic          m_over  = 1'b0;
   logic          m_under = 1'b0;
   logic          m_valid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         m_over  = 1'b0;
         m_under = 1'b0;
      end else if (flush_i) begin
         q.delete();
         m_over  = 1'b0;
         m_under = 1'b0;
      end else begin
         automatic bit was_full  = (q.size() == DEPTH);
         automatic bit was_empty = (q.size() == 0);
         m_over  = write_i && was_full;
         m_under = read_i && was_empty;
         if (read_i && !was_empty) void'(q.pop_front());
         if (write_i && !was_full) q.push_back(data_i);
      end
      m_valid = 1'b1;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("count", WW'(count_o), WW'(q.size()));
         check("empty", WW'(empty_o), WW'(q.size() == 0));
         check("full", WW'(full_o), WW'(q.size() == DEPTH));
         check("overflow", WW'(overflow_o), WW'(m_over));
         check("underflow", WW'(underflow_o), WW'(m_under));
         if (q.size() != 0) check("head", data_o, q[0]);
      end
   end

   task automatic drive(input logic w, input logic [WW-1:0] d, input logic r, input logic f);
      write_i = w;
      data_i  = d;
      read_i  = r;
      flush_i = f;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [WW-1:0] held;

      // 1: reset then idle
      rst = 1'b1;
      idle();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("rst_empty", WW'(empty_o), 1);
         check("rst_full", WW'(full_o), 0);
         check("rst_count", WW'(count_o), 0);
         check("rst_data", data_o, 0);
      end

      // 2: fill, overflow, drain in order
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, WW'(i), 1'b0, 1'b0);
         tick();
      end
      check("fill_full", WW'(full_o), 1);
      check("fill_count", WW'(count_o), 16);
      drive(1'b1, 32'hAA, 1'b0, 1'b0);
      tick();
      check("ovf_pulse", WW'(overflow_o), 1);
      check("ovf_count", WW'(count_o), 16);
      for (int i = 0; i < DEPTH; i++) begin
         check("drain_data", data_o, WW'(i));
         drive(1'b0, '0, 1'b1, 1'b0);
         tick();
      end
      check("drain_empty", WW'(empty_o), 1);
      idle();
      tick();

      // 3: bypass on write-into-empty and read+write at count 1
      drive(1'b1, 32'h1234, 1'b0, 1'b0);
      tick();
      check("byp_data", data_o, 32'h1234);
      check("byp_empty", WW'(empty_o), 0);
      drive(1'b1, 32'h5678, 1'b1, 1'b0);
      tick();
      check("rw1_data", data_o, 32'h5678);
      check("rw1_count", WW'(count_o), 1);
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();

      // 4: full with read+write: write dropped
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, WW'(32'h100 + i), 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 32'hBEEF, 1'b1, 1'b0);
      tick();
      check("fullrw_ovf", WW'(overflow_o), 1);
      check("fullrw_count", WW'(count_o), 15);
      for (int i = 1; i < DEPTH; i++) begin
         check("fullrw_data", data_o, WW'(32'h100 + i));
         drive(1'b0, '0, 1'b1, 1'b0);
         tick();
      end
      check("fullrw_empty", WW'(empty_o), 1);

      // 5: random traffic across pointer wrap
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
         tick();
      end
      idle();
      while (!empty_o) begin
         drive(1'b0, '0, 1'b1, 1'b0);
         tick();
      end
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
      check("undf_pulse", WW'(underflow_o), 1);
      check("undf_ovf", WW'(overflow_o), 0);

      // 6: flush with a concurrent write, then reset mid-burst
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, WW'(32'h700 + i), 1'b0, 1'b0);
         tick();
      end
      check("pre_flush_count", WW'(count_o), 7);
      held = data_o;
      drive(1'b1, 32'hDEAD, 1'b0, 1'b1);
      tick();
      check("flush_count", WW'(count_o), 0);
      check("flush_empty", WW'(empty_o), 1);
      check("flush_hold", data_o, held);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, WW'(32'h900 + i), 1'b1, 1'b0);
         tick();
      end
      rst = 1'b1;
      drive(1'b1, 32'h55, 1'b1, 1'b0);
      tick();
      rst = 1'b0;
      check("mid_rst_empty", WW'(empty_o), 1);
      check("mid_rst_full", WW'(full_o), 0);
      check("mid_rst_count", WW'(count_o), 0);
      check("mid_rst_data", data_o, 0);
      check("mid_rst_ovf", WW'(overflow_o), 0);
      check("mid_rst_udf", WW'(underflow_o), 0);
      idle();
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
